conv_front_row_scheduler: RTL and testbench
===========================================

Name: conv_front_row_scheduler

Overview:
- Sequences input-row fetches that fill the row buffers of the conv datapath front end (up to 3 row buffers, 32 pixels per row segment), then enables the datapath once per loaded window.
- Walks output rows, then input channels, then 32-pixel row segments, then kernel rows.
- Maps each (output row, kernel row) pair to an input row index. Padding rows become zero-fill requests.
- Sits between the layer-config/control logic and the feature-map read port plus datapath enable.

Parameters:
PIXELS_IN_ROW, 32, pixels per row segment (one row-buffer load)
PIXELS_IN_ROW_LOG2, 5, log2 of PIXELS_IN_ROW
BUFFERS_NUM, 3, number of row buffers (max k)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; single clock domain
start  in  1  one-cycle pulse; latches config when idle
k  in  4  kernel size, 1 or 3
s  in  4  stride, 1 or 2
p  in  4  padding, 0 or 1
oy  in  16  output rows
iy  in  16  input rows
ix_in_2pow  in  16  log2(ix)
nif_in_2pow  in  16  log2(input channels)
rd_ack  in  1  read port accepted request
win_ready  in  1  datapath consumed window
busy  out  1  high from cycle after start until done
done  out  1  one-cycle completion pulse
rd_req  out  1  row fetch request
rd_zero  out  1  request is padding row: buffer zero-fills, no memory access
rd_row  out  16  input row index (valid when rd_zero=0)
rd_ch  out  16  channel index
rd_seg  out  16  segment index
rd_buf_sel  out  2  target row buffer = ky
win_valid  out  1  k rows of current (oy_i, ch, seg) loaded; datapath enable
win_oy  out  16  output row of window
win_ch  out  16  channel of window
win_seg  out  16  segment of window

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately, with no done pulse.
- Config latching: on start in IDLE, latch all config. Derived values:
  - nseg = 1 << max(ix_in_2pow - PIXELS_IN_ROW_LOG2, 0)
  - nch = 1 << nif_in_2pow
- start while busy is ignored. Config inputs are don't-care after latching.
- States: IDLE -> ISSUE -> (WAIT_ACK | ZERO) -> ... -> FIRE -> ... -> DONE -> IDLE.
- Loop order, outer to inner: oy_i in [0,oy), ch in [0,nch), seg in [0,nseg), ky in [0,k).
- Row index: row = base + ky - p, signed 18-bit.
  - base is an accumulator that is +s per oy_i step. No multiplier.
  - Padding when row < 0 or row >= iy.
- ISSUE (one cycle after start, or after the previous completion):
  - Drive rd_req=1 with rd_row/rd_ch/rd_seg/rd_buf_sel.
  - Non-padding row -> WAIT_ACK.
  - Padding row -> ZERO, with rd_zero=1 and rd_row=0.
- WAIT_ACK: hold rd_req and all fields stable until rd_ack=1. rd_ack in the same cycle as rd_req completes the request. On ack, deassert next cycle.
- ZERO: request completes in this single cycle; rd_ack is ignored.
- After the request with ky=k-1 completes -> FIRE. Otherwise ky++ -> ISSUE.
- FIRE:
  - win_valid=1 with win_* fields; hold until win_ready=1.
  - On win_ready, advance seg / ch / oy_i with carries.
  - If the last window was fired -> DONE, else -> ISSUE.
- DONE: done=1 for one cycle, busy=0 that cycle, then IDLE.
- oy=0 at start: DONE the cycle after start, no requests issued.
- Outputs are registered. rd_req and win_valid are never high in the same cycle.
- Total requests = oy*nch*nseg*k. Total windows = oy*nch*nseg.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ISSUE, WAIT_ACK, ZERO, FIRE, DONE)
  - PIXELS_IN_ROW / PIXELS_IN_ROW_LOG2 / BUFFERS_NUM constants
  - the 16-bit dimension width constant
- One natural sub-module: conv_loop_counter, the nested oy_i/ch/seg/ky counter with carry-out and last flags, plus the base accumulator.
- The FSM stays in the top level.

Test Plan:
1. k=1,s=1,p=0,oy=2,iy=2,ix_in_2pow=5,nif_in_2pow=0, rd_ack tied 1, win_ready tied 1 -> requests row 0 then row 1 (ch0, seg0, buf0), 2 win_valid pulses (win_oy 0, 1), done once; rd_req first high 1 cycle after start.
2. k=3,s=1,p=1,oy=2,iy=2 -> oy0 rows: zero, 0, 1; oy1 rows: 0, 1, zero; zero requests last exactly 1 cycle with rd_ack held 0; rd_buf_sel 0, 1, 2 each window.
3. k=3,s=2,p=0,oy=2,iy=5,ix_in_2pow=6,nif_in_2pow=1 -> 24 requests ordered by ch, then seg, then ky; oy1 rows 2, 3, 4; 8 windows.
4. rd_ack delayed 5 cycles, win_ready low for 3 cycles -> rd_req/rd_row stable throughout the wait; win_valid held 4 cycles, counters unchanged until win_ready.
5. reset asserted during WAIT_ACK -> next cycle busy=0, rd_req=0, no done; a fresh start then runs scenario 1 correctly.
6. start pulsed mid-run -> ignored, request count unchanged; oy=0 -> done 1 cycle after start, zero requests.

Source files
------------

// File: rtl/conv_front_row_scheduler_pkg.sv
// Shared types and constants for the conv front-end row scheduler.
// Holds the FSM encoding and the row-buffer geometry used by the scheduler and its loop counter.
package conv_front_row_scheduler_pkg;

  localparam int PIXELS_IN_ROW      = 32;
  localparam int PIXELS_IN_ROW_LOG2 = 5;
  localparam int BUFFERS_NUM        = 3;
  localparam int DIM_W              = 16;
  // Channel/segment counts need one extra bit so that 1 << 16 stays representable.
  localparam int CNT_W              = DIM_W + 1;
  localparam int BASE_W             = DIM_W + 1;
  localparam int ROW_W              = 18;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    ZERO,
    FIRE,
    DONE
  } state_e;

  function automatic logic [CNT_W-1:0] seg_count(input logic [DIM_W-1:0] ix_log2);
    if (ix_log2 > DIM_W'(PIXELS_IN_ROW_LOG2))
      return CNT_W'(1) << (ix_log2 - DIM_W'(PIXELS_IN_ROW_LOG2));
    return CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] ch_count(input logic [DIM_W-1:0] nif_log2);
    return CNT_W'(1) << nif_log2;
  endfunction

endpackage

// File: rtl/conv_loop_counter.sv
// Nested oy_i / ch / seg / ky loop counter with carry chain and the stride accumulator.
// Next-state values are exported so the scheduler can register its outputs one cycle ahead.
module conv_loop_counter
  import conv_front_row_scheduler_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              ky_step_i,
  input  logic              win_step_i,
  input  logic [3:0]        k_i,
  input  logic [3:0]        s_i,
  input  logic [DIM_W-1:0]  oy_i,
  input  logic [CNT_W-1:0]  nch_i,
  input  logic [CNT_W-1:0]  nseg_i,
  output logic [DIM_W-1:0]  orow_d_o,
  output logic [DIM_W-1:0]  ch_d_o,
  output logic [DIM_W-1:0]  seg_d_o,
  output logic [3:0]        ky_d_o,
  output logic [BASE_W-1:0] base_d_o,
  output logic              ky_last_o,
  output logic              win_last_o
);

  logic [DIM_W-1:0]  orow_q, orow_d;
  logic [DIM_W-1:0]  ch_q, ch_d;
  logic [DIM_W-1:0]  seg_q, seg_d;
  logic [3:0]        ky_q, ky_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              seg_last, ch_last, orow_last;

  assign seg_last   = ({1'b0, seg_q} == nseg_i - CNT_W'(1));
  assign ch_last    = ({1'b0, ch_q} == nch_i - CNT_W'(1));
  assign orow_last  = (orow_q == oy_i - DIM_W'(1));
  assign ky_last_o  = (ky_q == k_i - 4'd1);
  assign win_last_o = orow_last && ch_last && seg_last;

  always_comb begin
    orow_d = orow_q;
    ch_d   = ch_q;
    seg_d  = seg_q;
    ky_d   = ky_q;
    base_d = base_q;
    if (load_i) begin
      orow_d = '0;
      ch_d   = '0;
      seg_d  = '0;
      ky_d   = '0;
      base_d = '0;
    end else if (ky_step_i) begin
      ky_d = ky_q + 4'd1;
    end else if (win_step_i) begin
      ky_d = '0;
      if (!seg_last) begin
        seg_d = seg_q + DIM_W'(1);
      end else begin
        seg_d = '0;
        if (!ch_last) begin
          ch_d = ch_q + DIM_W'(1);
        end else begin
          ch_d   = '0;
          orow_d = orow_q + DIM_W'(1);
          // base tracks orow * s without a multiplier
          base_d = base_q + BASE_W'(s_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      orow_q <= '0;
      ch_q   <= '0;
      seg_q  <= '0;
      ky_q   <= '0;
      base_q <= '0;
    end else begin
      orow_q <= orow_d;
      ch_q   <= ch_d;
      seg_q  <= seg_d;
      ky_q   <= ky_d;
      base_q <= base_d;
    end
  end

  assign orow_d_o = orow_d;
  assign ch_d_o   = ch_d;
  assign seg_d_o  = seg_d;
  assign ky_d_o   = ky_d;
  assign base_d_o = base_d;

endmodule

// File: rtl/conv_front_row_scheduler.sv
// Row-fetch scheduler for the conv front end: issues k row loads per (oy_i, ch, seg) window,
// zero-filling padding rows, then enables the datapath once per loaded window.
module conv_front_row_scheduler
  import conv_front_row_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       k,
  input  logic [3:0]       s,
  input  logic [3:0]       p,
  input  logic [DIM_W-1:0] oy,
  input  logic [DIM_W-1:0] iy,
  input  logic [DIM_W-1:0] ix_in_2pow,
  input  logic [DIM_W-1:0] nif_in_2pow,
  input  logic             rd_ack,
  input  logic             win_ready,
  output logic             busy,
  output logic             done,
  output logic             rd_req,
  output logic             rd_zero,
  output logic [DIM_W-1:0] rd_row,
  output logic [DIM_W-1:0] rd_ch,
  output logic [DIM_W-1:0] rd_seg,
  output logic [1:0]       rd_buf_sel,
  output logic             win_valid,
  output logic [DIM_W-1:0] win_oy,
  output logic [DIM_W-1:0] win_ch,
  output logic [DIM_W-1:0] win_seg
);

  state_e state_q, state_d, next_req;

  logic [3:0]       k_q, s_q, p_q;
  logic [DIM_W-1:0] oy_q, iy_q;
  logic [CNT_W-1:0] nch_q, nseg_q;

  logic             start_idle;
  logic [3:0]       p_cfg;
  logic [DIM_W-1:0] iy_cfg;

  logic              req_done, ky_step, win_step;
  logic [DIM_W-1:0]  orow_d, ch_d, seg_d;
  logic [3:0]        ky_d;
  logic [BASE_W-1:0] base_d;
  logic              ky_last, win_last;

  logic signed [ROW_W-1:0] row_d;
  logic                    pad_d;
  logic                    issuing_d;

  logic             busy_q, done_q, rd_req_q, rd_zero_q, win_valid_q;
  logic [DIM_W-1:0] rd_row_q, rd_ch_q, rd_seg_q, win_oy_q, win_ch_q, win_seg_q;
  logic [1:0]       rd_buf_sel_q;

  assign start_idle = start && (state_q == IDLE);
  // The first request is decided in the same cycle config is captured, so use the live inputs then.
  assign p_cfg  = start_idle ? p  : p_q;
  assign iy_cfg = start_idle ? iy : iy_q;

  assign req_done = ((state_q == ISSUE || state_q == WAIT_ACK) && rd_ack) || (state_q == ZERO);
  assign ky_step  = req_done && !ky_last;
  assign win_step = (state_q == FIRE) && win_ready;

  conv_loop_counter u_loop (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (start_idle),
    .ky_step_i  (ky_step),
    .win_step_i (win_step),
    .k_i        (k_q),
    .s_i        (s_q),
    .oy_i       (oy_q),
    .nch_i      (nch_q),
    .nseg_i     (nseg_q),
    .orow_d_o   (orow_d),
    .ch_d_o     (ch_d),
    .seg_d_o    (seg_d),
    .ky_d_o     (ky_d),
    .base_d_o   (base_d),
    .ky_last_o  (ky_last),
    .win_last_o (win_last)
  );

  assign row_d = $signed({1'b0, base_d}) + $signed({14'b0, ky_d}) - $signed({14'b0, p_cfg});
  assign pad_d = row_d[ROW_W-1] || (row_d >= $signed({2'b0, iy_cfg}));
  assign next_req = pad_d ? ZERO : ISSUE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (oy == '0) ? DONE : next_req;
      end
      ISSUE, WAIT_ACK: begin
        if (rd_ack) state_d = ky_last ? FIRE : next_req;
        else        state_d = WAIT_ACK;
      end
      ZERO: state_d = ky_last ? FIRE : next_req;
      FIRE: begin
        if (win_ready) state_d = win_last ? DONE : next_req;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign issuing_d = (state_d == ISSUE) || (state_d == WAIT_ACK) || (state_d == ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      oy_q    <= '0;
      iy_q    <= '0;
      nch_q   <= '0;
      nseg_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_idle) begin
        k_q    <= k;
        s_q    <= s;
        p_q    <= p;
        oy_q   <= oy;
        iy_q   <= iy;
        nch_q  <= ch_count(nif_in_2pow);
        nseg_q <= seg_count(ix_in_2pow);
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_zero_q    <= 1'b0;
      rd_row_q     <= '0;
      rd_ch_q      <= '0;
      rd_seg_q     <= '0;
      rd_buf_sel_q <= '0;
      win_valid_q  <= 1'b0;
      win_oy_q     <= '0;
      win_ch_q     <= '0;
      win_seg_q    <= '0;
    end else begin
      busy_q       <= (state_d != IDLE) && (state_d != DONE);
      done_q       <= (state_d == DONE);
      rd_req_q     <= issuing_d;
      rd_zero_q    <= (state_d == ZERO);
      rd_row_q     <= (issuing_d && state_d != ZERO) ? row_d[DIM_W-1:0] : '0;
      rd_ch_q      <= issuing_d ? ch_d : '0;
      rd_seg_q     <= issuing_d ? seg_d : '0;
      rd_buf_sel_q <= issuing_d ? ky_d[1:0] : '0;
      win_valid_q  <= (state_d == FIRE);
      win_oy_q     <= (state_d == FIRE) ? orow_d : '0;
      win_ch_q     <= (state_d == FIRE) ? ch_d : '0;
      win_seg_q    <= (state_d == FIRE) ? seg_d : '0;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_req     = rd_req_q;
  assign rd_zero    = rd_zero_q;
  assign rd_row     = rd_row_q;
  assign rd_ch      = rd_ch_q;
  assign rd_seg     = rd_seg_q;
  assign rd_buf_sel = rd_buf_sel_q;
  assign win_valid  = win_valid_q;
  assign win_oy     = win_oy_q;
  assign win_ch     = win_ch_q;
  assign win_seg    = win_seg_q;

endmodule

// File: tb/tb_conv_front_row_scheduler.sv
// Self-checking bench for conv_front_row_scheduler: table of configs with hand totals,
// a loop-nest reference model of the request/window stream, and random handshakes.
module tb_conv_front_row_scheduler;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  k, s, p;
  logic [15:0] oy, iy, ix_in_2pow, nif_in_2pow;
  logic        rd_ack, win_ready;
  logic        busy, done, rd_req, rd_zero, win_valid;
  logic [15:0] rd_row, rd_ch, rd_seg, win_oy, win_ch, win_seg;
  logic [1:0]  rd_buf_sel;

  always #5 clk = ~clk;

  conv_front_row_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .s(s), .p(p), .oy(oy), .iy(iy),
    .ix_in_2pow(ix_in_2pow), .nif_in_2pow(nif_in_2pow), .rd_ack(rd_ack), .win_ready(win_ready),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_zero(rd_zero), .rd_row(rd_row),
    .rd_ch(rd_ch), .rd_seg(rd_seg), .rd_buf_sel(rd_buf_sel), .win_valid(win_valid),
    .win_oy(win_oy), .win_ch(win_ch), .win_seg(win_seg)
  );

  // mode: 0 = handshakes tied high, 1 = random, 2 = ack after 5 held cycles / ready after 3
  typedef struct {
    int k, s, p, oy, iy, ix, nif, mode;
    int exp_req, exp_win, exp_zero;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  int q_row[$], q_zero[$], q_ch[$], q_seg[$], q_buf[$];
  int q_woy[$], q_wch[$], q_wseg[$];

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic build_model(input vec_t v);
    int nch, nseg, r;
    q_row.delete(); q_zero.delete(); q_ch.delete(); q_seg.delete(); q_buf.delete();
    q_woy.delete(); q_wch.delete(); q_wseg.delete();
    nch  = 1 << v.nif;
    nseg = (v.ix > 5) ? (1 << (v.ix - 5)) : 1;
    for (int o = 0; o < v.oy; o++)
      for (int c = 0; c < nch; c++)
        for (int g = 0; g < nseg; g++) begin
          for (int y = 0; y < v.k; y++) begin
            r = o * v.s + y - v.p;
            q_zero.push_back((r < 0 || r >= v.iy) ? 1 : 0);
            q_row.push_back((r < 0 || r >= v.iy) ? 0 : r);
            q_ch.push_back(c); q_seg.push_back(g); q_buf.push_back(y);
          end
          q_woy.push_back(o); q_wch.push_back(c); q_wseg.push_back(g);
        end
  endtask

  task automatic drive_hs(input int mode, input int age_r, input int age_w);
    case (mode)
      0: begin rd_ack = 1'b1; win_ready = 1'b1; end
      1: begin rd_ack = 1'($urandom_range(0, 1)); win_ready = 1'($urandom_range(0, 1)); end
      default: begin rd_ack = (age_r >= 5); win_ready = (age_w >= 3); end
    endcase
  endtask

  task automatic run_cfg(input vec_t v, output int nreq, output int nwin, output int nzero);
    int cyc, age_r, age_w;
    bit fin, hr, hw, cmpl;
    int sr_row, sr_ch, sr_seg, sr_buf, sr_zero, sw_oy, sw_ch, sw_seg;
    build_model(v);
    nreq = 0; nwin = 0; nzero = 0;
    @(posedge clk); #1;
    k = 4'(v.k); s = 4'(v.s); p = 4'(v.p); oy = 16'(v.oy); iy = 16'(v.iy);
    ix_in_2pow = 16'(v.ix); nif_in_2pow = 16'(v.nif);
    start = 1'b1;
    drive_hs(v.mode, 0, 0);
    @(posedge clk); #1;
    start = 1'b0;
    // config must have been captured: scramble it for the rest of the run
    k = 4'($urandom); s = 4'($urandom); p = 4'($urandom); oy = 16'($urandom);
    iy = 16'($urandom); ix_in_2pow = 16'($urandom_range(0, 9)); nif_in_2pow = 16'($urandom_range(0, 4));
    cyc = 0; fin = 0; hr = 0; hw = 0; age_r = 0; age_w = 0;
    sr_row = 0; sr_ch = 0; sr_seg = 0; sr_buf = 0; sr_zero = 0; sw_oy = 0; sw_ch = 0; sw_seg = 0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      if (cyc == 0 && v.mode == 0) check("first_cycle_latency", (v.oy == 0) ? done : rd_req, 1);
      check("req_win_exclusive", rd_req & win_valid, 0);
      if (rd_req || win_valid) check("busy_active", busy, 1);
      if (hr) begin
        check("req_held", rd_req, 1);
        check("row_held", rd_row, sr_row);
        check("ch_held", rd_ch, sr_ch);
        check("seg_held", rd_seg, sr_seg);
        check("buf_held", rd_buf_sel, sr_buf);
        check("zero_held", rd_zero, sr_zero);
      end
      if (rd_req) begin
        cmpl = rd_zero || rd_ack;
        if (cmpl) begin
          if (q_row.size() == 0) check("req_overflow", q_row.size(), 1);
          else begin
            check("rd_zero", rd_zero, q_zero.pop_front());
            check("rd_row", rd_row, q_row.pop_front());
            check("rd_ch", rd_ch, q_ch.pop_front());
            check("rd_seg", rd_seg, q_seg.pop_front());
            check("rd_buf_sel", rd_buf_sel, q_buf.pop_front());
          end
          if (v.mode == 2) check("req_wait_cycles", age_r, rd_zero ? 0 : 5);
          nreq++;
          if (rd_zero) nzero++;
        end
        hr = !cmpl;
        age_r = cmpl ? 0 : age_r + 1;
        sr_row = rd_row; sr_ch = rd_ch; sr_seg = rd_seg; sr_buf = rd_buf_sel; sr_zero = rd_zero;
      end else begin
        hr = 0; age_r = 0;
      end
      if (hw) begin
        check("win_held", win_valid, 1);
        check("win_oy_held", win_oy, sw_oy);
        check("win_ch_held", win_ch, sw_ch);
        check("win_seg_held", win_seg, sw_seg);
      end
      if (win_valid) begin
        cmpl = win_ready;
        if (cmpl) begin
          if (q_woy.size() == 0) check("win_overflow", q_woy.size(), 1);
          else begin
            check("win_oy", win_oy, q_woy.pop_front());
            check("win_ch", win_ch, q_wch.pop_front());
            check("win_seg", win_seg, q_wseg.pop_front());
          end
          if (v.mode == 2) check("win_hold_cycles", age_w, 3);
          nwin++;
        end
        hw = !cmpl;
        age_w = cmpl ? 0 : age_w + 1;
        sw_oy = win_oy; sw_ch = win_ch; sw_seg = win_seg;
      end else begin
        hw = 0; age_w = 0;
      end
      if (done) begin
        fin = 1;
        check("busy_low_at_done", busy, 0);
      end
      @(posedge clk); #1;
      drive_hs(v.mode, age_r, age_w);
      start = (cyc == 3);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", fin, 1);
    check("reqs_outstanding", q_row.size(), 0);
    check("wins_outstanding", q_woy.size(), 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  vec_t tbl[7];
  vec_t rv;
  int nr, nw, nz, seen;

  initial begin
    tbl[0] = '{k:1, s:1, p:0, oy:2, iy:2, ix:5, nif:0, mode:0, exp_req:2,  exp_win:2,  exp_zero:0};
    tbl[1] = '{k:3, s:1, p:1, oy:2, iy:2, ix:5, nif:0, mode:2, exp_req:6,  exp_win:2,  exp_zero:2};
    tbl[2] = '{k:3, s:2, p:0, oy:2, iy:5, ix:6, nif:1, mode:0, exp_req:24, exp_win:8,  exp_zero:0};
    tbl[3] = '{k:3, s:2, p:0, oy:2, iy:5, ix:6, nif:1, mode:2, exp_req:24, exp_win:8,  exp_zero:0};
    tbl[4] = '{k:3, s:1, p:1, oy:0, iy:4, ix:5, nif:0, mode:0, exp_req:0,  exp_win:0,  exp_zero:0};
    tbl[5] = '{k:3, s:2, p:1, oy:3, iy:5, ix:5, nif:0, mode:1, exp_req:9,  exp_win:3,  exp_zero:2};
    tbl[6] = '{k:1, s:2, p:1, oy:3, iy:4, ix:7, nif:2, mode:1, exp_req:48, exp_win:48, exp_zero:16};

    reset = 1'b1; start = 1'b0; rd_ack = 1'b0; win_ready = 1'b0;
    k = '0; s = '0; p = '0; oy = '0; iy = '0; ix_in_2pow = '0; nif_in_2pow = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_rd_req", rd_req, 0);
    check("reset_win_valid", win_valid, 0);
    check("reset_rd_row", rd_row, 0);
    check("reset_rd_buf_sel", rd_buf_sel, 0);
    @(posedge clk); #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_cfg(tbl[i], nr, nw, nz);
      check($sformatf("vec%0d_requests", i), nr, tbl[i].exp_req);
      check($sformatf("vec%0d_windows", i), nw, tbl[i].exp_win);
      check($sformatf("vec%0d_zero_reqs", i), nz, tbl[i].exp_zero);
    end

    // reset while a request waits for its ack
    @(posedge clk); #1;
    k = 4'd1; s = 4'd1; p = 4'd0; oy = 16'd2; iy = 16'd2; ix_in_2pow = 16'd5; nif_in_2pow = 16'd0;
    start = 1'b1; rd_ack = 1'b0; win_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    check("wait_ack_req_high", rd_req, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_rd_req", rd_req, 0);
    check("abort_done", done, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || rd_req) seen++;
    end
    check("abort_stays_idle", seen, 0);
    run_cfg(tbl[0], nr, nw, nz);
    check("post_reset_requests", nr, 2);
    check("post_reset_windows", nw, 2);

    // random configurations with random handshakes
    for (int t = 0; t < 10; t++) begin
      rv.k = ($urandom_range(0, 1) != 0) ? 3 : 1;
      rv.s = $urandom_range(1, 2);
      rv.p = $urandom_range(0, 1);
      rv.oy = $urandom_range(0, 4);
      rv.iy = $urandom_range(1, 6);
      rv.ix = $urandom_range(3, 7);
      rv.nif = $urandom_range(0, 2);
      rv.mode = 1;
      rv.exp_win = rv.oy * (1 << rv.nif) * ((rv.ix > 5) ? (1 << (rv.ix - 5)) : 1);
      rv.exp_req = rv.exp_win * rv.k;
      rv.exp_zero = 0;
      run_cfg(rv, nr, nw, nz);
      check($sformatf("rand%0d_requests", t), nr, rv.exp_req);
      check($sformatf("rand%0d_windows", t), nw, rv.exp_win);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
